// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial add/subtract unit.
package serial_add_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_add_bit.sv
// Combinational one-bit full adder used once per serial bit step.
module full_add_bit (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);

    assign o_s    = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/serial_addsub4.sv
// Bit-serial add/subtract: one bit per clock through a single carry flip-flop,
// with start/busy/done handshake and signed-overflow reporting.
module serial_addsub4
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             c_in_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             c_out_o,
    output logic             ovf_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;
    logic               w_last;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_s;
    logic               w_cout;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;

    full_add_bit u_fa (
        .i_a    (r_a[0]),
        .i_b    (r_b[0]),
        .i_cin  (r_carry),
        .o_s    (w_s),
        .o_cout (w_cout)
    );

    // State register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control strobes; start_i is only looked at in IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: subtract is a + ~b + 1, so the carry FF is preset to 1
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a     <= a_i;
                r_b     <= sub_i ? ~b_i : b_i;
                r_carry <= sub_i ? 1'b1 : c_in_i;
                r_cnt   <= '0;
            end else if (r_state == SHIFT) begin
                r_a     <= r_a >> 1;
                r_b     <= r_b >> 1;
                r_res   <= {w_s, r_res[WIDTH-1:1]};
                r_carry <= w_cout;
                r_cnt   <= r_cnt + CNT_W'(1);
            end
            // Results publish atomically so consumers never see partial sums
            if (w_last) begin
                r_sum  <= {w_s, r_res[WIDTH-1:1]};
                r_cout <= w_cout;
                r_ovf  <= r_carry ^ w_cout;
            end
            r_busy <= (w_state_nxt != IDLE);
            r_done <= (w_state_nxt == DONE);
        end
    end

    assign busy_o  = r_busy;
    assign done_o  = r_done;
    assign sum_o   = r_sum;
    assign c_out_o = r_cout;
    assign ovf_o   = r_ovf;

endmodule

// File: tb/tb_serial_addsub4.sv
// Self-checking bench for serial_addsub4: directed 4-bit vectors, handshake
// corner cases, and a randomised 8-bit add/sub regression.
module tb_serial_addsub4;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       sub;
        logic       cin;
        logic [3:0] sum;
        logic       cout;
        logic       ovf;
        string      name;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       s4_start, s4_sub, s4_cin;
    logic [3:0] s4_a, s4_b, s4_sum;
    logic       s4_busy, s4_done, s4_cout, s4_ovf;
    logic       s8_start, s8_sub, s8_cin;
    logic [7:0] s8_a, s8_b, s8_sum;
    logic       s8_busy, s8_done, s8_cout, s8_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    serial_addsub4 #(.WIDTH(4)) dut4 (
        .clk_i   (clk),
        .reset_i (reset),
        .start_i (s4_start),
        .sub_i   (s4_sub),
        .a_i     (s4_a),
        .b_i     (s4_b),
        .c_in_i  (s4_cin),
        .busy_o  (s4_busy),
        .done_o  (s4_done),
        .sum_o   (s4_sum),
        .c_out_o (s4_cout),
        .ovf_o   (s4_ovf)
    );

    serial_addsub4 #(.WIDTH(8)) dut8 (
        .clk_i   (clk),
        .reset_i (reset),
        .start_i (s8_start),
        .sub_i   (s8_sub),
        .a_i     (s8_a),
        .b_i     (s8_b),
        .c_in_i  (s8_cin),
        .busy_o  (s8_busy),
        .done_o  (s8_done),
        .sum_o   (s8_sum),
        .c_out_o (s8_cout),
        .ovf_o   (s8_ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One full 4-bit request with per-cycle busy/done and result checks
    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic sub,
                        input logic cin, input logic [3:0] esum, input logic ecout,
                        input logic eovf, input string tag);
        logic [3:0] prev_sum;
        logic       prev_cout;
        @(negedge clk);
        s4_a = a; s4_b = b; s4_sub = sub; s4_cin = cin; s4_start = 1'b1;
        prev_sum  = s4_sum;
        prev_cout = s4_cout;
        @(posedge clk);
        #1;
        s4_start = 1'b0;
        s4_a = ~a; s4_b = ~b; s4_sub = ~sub; s4_cin = ~cin;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk({tag, "/busy"}, 32'(s4_busy), 32'(k <= 5));
            chk({tag, "/done"}, 32'(s4_done), 32'(k == 5));
            if (k == 3) begin
                chk({tag, "/hold_sum"}, 32'(s4_sum), 32'(prev_sum));
                chk({tag, "/hold_cout"}, 32'(s4_cout), 32'(prev_cout));
            end
            if (k == 5) begin
                chk({tag, "/sum"}, 32'(s4_sum), 32'(esum));
                chk({tag, "/cout"}, 32'(s4_cout), 32'(ecout));
                chk({tag, "/ovf"}, 32'(s4_ovf), 32'(eovf));
            end
        end
    endtask

    vec_t vecs[9];

    initial begin
        int dn;
        vecs[0] = '{4'h7, 4'h8, 1'b0, 1'b1, 4'h0, 1'b1, 1'b0, "add_cin"};
        vecs[1] = '{4'h7, 4'h1, 1'b0, 1'b0, 4'h8, 1'b0, 1'b1, "add_ovf"};
        vecs[2] = '{4'h3, 4'h5, 1'b1, 1'b1, 4'hE, 1'b0, 1'b0, "sub_neg"};
        vecs[3] = '{4'h8, 4'h1, 1'b1, 1'b0, 4'h7, 1'b1, 1'b1, "sub_ovf"};
        vecs[4] = '{4'hF, 4'hF, 1'b0, 1'b1, 4'hF, 1'b1, 1'b0, "add_max"};
        vecs[5] = '{4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, "add_zero"};
        vecs[6] = '{4'h4, 4'h4, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, "sub_eq"};
        vecs[7] = '{4'h5, 4'h5, 1'b0, 1'b0, 4'hA, 1'b0, 1'b1, "add_pos_ovf"};
        vecs[8] = '{4'h0, 4'h1, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0, "sub_borrow"};

        reset = 1'b1;
        s4_start = 1'b0; s4_sub = 1'b0; s4_cin = 1'b0; s4_a = '0; s4_b = '0;
        s8_start = 1'b0; s8_sub = 1'b0; s8_cin = 1'b0; s8_a = '0; s8_b = '0;
        repeat (2) @(negedge clk);
        chk("reset/busy", 32'(s4_busy), 32'd0);
        chk("reset/done", 32'(s4_done), 32'd0);
        chk("reset/sum", 32'(s4_sum), 32'd0);
        chk("reset/cout", 32'(s4_cout), 32'd0);
        chk("reset/ovf", 32'(s4_ovf), 32'd0);
        chk("reset/sum8", 32'(s8_sum), 32'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            run4(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin,
                 vecs[i].sum, vecs[i].cout, vecs[i].ovf, vecs[i].name);
        end

        // Start while busy: pulses at edges 2 and 5 must be ignored
        dn = 0;
        for (int c = 0; c <= 11; c++) begin
            @(negedge clk);
            if (c >= 1 && s4_done) dn++;
            if (c == 5) begin
                chk("busy_start/done5", 32'(s4_done), 32'd1);
                chk("busy_start/sum5", 32'(s4_sum), 32'h5);
                chk("busy_start/cout5", 32'(s4_cout), 32'd0);
            end
            if (c == 6) chk("busy_start/idle6", 32'(s4_busy), 32'd0);
            if (c == 7) chk("busy_start/busy7", 32'(s4_busy), 32'd1);
            if (c == 11) begin
                chk("busy_start/done11", 32'(s4_done), 32'd1);
                chk("busy_start/sum11", 32'(s4_sum), 32'hE);
                chk("busy_start/cout11", 32'(s4_cout), 32'd1);
            end
            s4_sub = 1'b0; s4_cin = 1'b0;
            s4_start = (c == 0 || c == 2 || c == 5 || c == 6);
            s4_a = (c == 0) ? 4'h2 : 4'hF;
            s4_b = (c == 0) ? 4'h3 : 4'hF;
        end
        s4_start = 1'b0;
        chk("busy_start/done_count", 32'(dn), 32'd2);

        // Asynchronous reset in the middle of a request
        @(negedge clk);
        s4_a = 4'h9; s4_b = 4'h4; s4_start = 1'b1;
        @(posedge clk);
        #1 s4_start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid/busy", 32'(s4_busy), 32'd0);
        chk("rst_mid/done", 32'(s4_done), 32'd0);
        chk("rst_mid/sum", 32'(s4_sum), 32'd0);
        chk("rst_mid/cout", 32'(s4_cout), 32'd0);
        chk("rst_mid/ovf", 32'(s4_ovf), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        dn = 0;
        repeat (8) begin
            @(negedge clk);
            if (s4_done) dn++;
        end
        chk("rst_mid/no_done", 32'(dn), 32'd0);
        run4(4'h1, 4'h1, 1'b0, 1'b0, 4'h2, 1'b0, 1'b0, "rst_after");

        // Random 8-bit regression against an integer reference
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] a, b, esum;
            logic       sub, cin, ecout, eovf;
            int         sa, sb, sr, tot, lat;
            a   = 8'($urandom);
            b   = 8'($urandom);
            sub = 1'($urandom_range(0, 1));
            cin = 1'($urandom_range(0, 1));
            sa  = int'($signed(a));
            sb  = int'($signed(b));
            if (sub) begin
                esum  = a - b;
                ecout = (a >= b);
                sr    = sa - sb;
            end else begin
                tot   = int'(a) + int'(b) + int'(cin);
                esum  = 8'(tot);
                ecout = (tot > 255);
                sr    = sa + sb + int'(cin);
            end
            eovf = (sr > 127) || (sr < -128);

            @(negedge clk);
            s8_a = a; s8_b = b; s8_sub = sub; s8_cin = cin; s8_start = 1'b1;
            @(posedge clk);
            #1 s8_start = 1'b0;
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (!s8_done && lat < 20);
            chk("rand/latency", 32'(lat), 32'd9);
            chk("rand/sum", 32'(s8_sum), 32'(esum));
            chk("rand/cout", 32'(s8_cout), 32'(ecout));
            chk("rand/ovf", 32'(s8_ovf), 32'(eovf));
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
